// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the MIPS64 pipeline stages.
//   - RW_*  : memory operation encodings carried on rw_e
//   - LEN_* : access size encodings carried on rw_len
//   - ma_state_t : states of the memory-access stage FSM
//   - is_misaligned() : alignment rule shared by the MA and cache stages
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam logic [1:0] RW_NONE = 2'b00;
    localparam logic [1:0] RW_LD   = 2'b01;
    localparam logic [1:0] RW_ST   = 2'b10;

    localparam logic [1:0] LEN_B   = 2'b00;
    localparam logic [1:0] LEN_H   = 2'b01;
    localparam logic [1:0] LEN_W   = 2'b10;

    typedef enum logic [1:0] {
        MA_IDLE = 2'd0,
        MA_MEM  = 2'd1,
        MA_OUT  = 2'd2
    } ma_state_t;

    // Halves must sit on even addresses, words on multiples of four.
    // The reserved length code 11 behaves like a word.
    function automatic logic is_misaligned(input logic [1:0] len, input logic [1:0] addr_lo);
        case (len)
            LEN_B:   return 1'b0;
            LEN_H:   return addr_lo[0];
            default: return (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/ma_lane_fmt.sv
// ---------------------------------------------------------------------------
// ma_lane_fmt
// Combinational byte-lane formatter between a core register and a 32-bit
// memory word. Replicates store data across lanes, builds byte enables,
// and extracts / extends load data.
//   i_addr_lo  : low two address bits selecting the lane
//   i_len      : access size (LEN_B / LEN_H / LEN_W, 11 treated as word)
//   i_ld_uns   : zero-extend loads when set, sign-extend when clear
//   i_st_val   : store data from the register file
//   i_rdata    : raw memory read word
//   o_wdata    : lane-replicated store data
//   o_be       : byte enables for the store
//   o_ld_data  : shifted and extended load result
// ---------------------------------------------------------------------------
module ma_lane_fmt
    import pipe_pkg::*;
#(
    parameter int REG_SZ = 32
) (
    input  logic [1:0]        i_addr_lo,
    input  logic [1:0]        i_len,
    input  logic              i_ld_uns,
    input  logic [REG_SZ-1:0] i_st_val,
    input  logic [REG_SZ-1:0] i_rdata,
    output logic [REG_SZ-1:0] o_wdata,
    output logic [3:0]        o_be,
    output logic [REG_SZ-1:0] o_ld_data
);

    logic [REG_SZ-1:0] w_shifted;

    // The addressed byte is brought down to lane 0 before extension.
    assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};

    // Word access is the default; byte and half override the lanes they touch.
    always_comb begin
        o_wdata   = i_st_val;
        o_be      = 4'b1111;
        o_ld_data = w_shifted;
        case (i_len)
            LEN_B: begin
                o_wdata   = {(REG_SZ/8){i_st_val[7:0]}};
                o_be      = 4'b0001 << i_addr_lo;
                o_ld_data = {{(REG_SZ-8){~i_ld_uns & w_shifted[7]}}, w_shifted[7:0]};
            end
            LEN_H: begin
                o_wdata   = {(REG_SZ/16){i_st_val[15:0]}};
                o_be      = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_ld_data = {{(REG_SZ-16){~i_ld_uns & w_shifted[15]}}, w_shifted[15:0]};
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/pipe_ma.sv
// ---------------------------------------------------------------------------
// pipe_ma
// Memory-access stage of the MIPS64 pipeline. Accepts one executed
// instruction per handshake, performs loads/stores on the data-memory port,
// passes ALU results through, and publishes results on the MA->EX
// forwarding bus.
//   clk, rst                  : clock, synchronous active-high reset
//   in_valid/in_ready         : handshake from execute
//   in_ans, in_val            : ALU result / address, store data
//   in_rw_e, in_rw_len        : memory op kind and size
//   in_ld_uns                 : zero-extend loads
//   in_wb_e, in_wb_idx        : write-back enable and destination
//   mem_*                     : data-memory request port (held until mem_ack)
//   wb_valid/wb_ready         : handshake to write-back
//   wb_e_out, wb_idx_out, wb_data : held result
//   MA_fwd_idx, MA_fwd_val, MA_ack : forwarding bus to execute
//   misalign_err              : sticky misaligned-access flag
// ---------------------------------------------------------------------------
module pipe_ma
    import pipe_pkg::*;
#(
    parameter int REG_SZ = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_SZ-1:0] in_ans,
    input  logic [REG_SZ-1:0] in_val,
    input  logic [1:0]        in_rw_e,
    input  logic [1:0]        in_rw_len,
    input  logic              in_ld_uns,
    input  logic              in_wb_e,
    input  logic [4:0]        in_wb_idx,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [REG_SZ-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [REG_SZ-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic              wb_e_out,
    output logic [4:0]        wb_idx_out,
    output logic [REG_SZ-1:0] wb_data,
    output logic [4:0]        MA_fwd_idx,
    output logic [31:0]       MA_fwd_val,
    output logic              MA_ack,
    output logic              misalign_err
);

    ma_state_t r_state, w_next_state;

    logic              w_accept;
    logic              w_is_mem;
    logic              w_misalign;
    logic [ADDR_W-1:0] w_addr;

    // Instruction fields kept while the memory access is outstanding.
    logic              r_pend_st;
    logic              r_pend_wb_e;
    logic [4:0]        r_pend_idx;
    logic [1:0]        r_pend_len;
    logic [1:0]        r_pend_lo;
    logic              r_pend_uns;

    logic              r_mem_req, r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [REG_SZ-1:0] r_mem_wdata;
    logic [3:0]        r_mem_be;
    logic              r_wb_e;
    logic [4:0]        r_wb_idx;
    logic [REG_SZ-1:0] r_wb_data;
    logic [4:0]        r_fwd_idx;
    logic              r_ma_ack;
    logic              r_misalign;

    logic [1:0]        w_fmt_lo, w_fmt_len;
    logic [REG_SZ-1:0] w_fmt_wdata, w_fmt_ld;
    logic [3:0]        w_fmt_be;

    assign w_is_mem   = (in_rw_e == RW_LD) || (in_rw_e == RW_ST);
    assign w_misalign = w_is_mem && is_misaligned(in_rw_len, in_ans[1:0]);
    assign w_addr     = ADDR_W'(in_ans);

    // One formatter serves both directions: in MEM it extracts the pending
    // load, elsewhere it formats the store being accepted (accepts never
    // happen in MEM, so the two uses cannot collide).
    assign w_fmt_lo  = (r_state == MA_MEM) ? r_pend_lo  : in_ans[1:0];
    assign w_fmt_len = (r_state == MA_MEM) ? r_pend_len : in_rw_len;

    ma_lane_fmt #(.REG_SZ(REG_SZ)) u_fmt (
        .i_addr_lo (w_fmt_lo),
        .i_len     (w_fmt_len),
        .i_ld_uns  (r_pend_uns),
        .i_st_val  (in_val),
        .i_rdata   (mem_rdata),
        .o_wdata   (w_fmt_wdata),
        .o_be      (w_fmt_be),
        .o_ld_data (w_fmt_ld)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= MA_IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state and handshake. OUT can retire and accept in the same edge,
    // so an accept overrides the plain OUT->IDLE transition.
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        case (r_state)
            MA_IDLE: in_ready = 1'b1;
            MA_MEM:  if (mem_ack) w_next_state = MA_OUT;
            MA_OUT: begin
                in_ready = wb_ready;
                if (wb_ready) w_next_state = MA_IDLE;
            end
            default: w_next_state = MA_IDLE;
        endcase
        w_accept = in_valid & in_ready;
        if (w_accept) w_next_state = (w_is_mem && !w_misalign) ? MA_MEM : MA_OUT;
    end

    // Datapath: memory request, result register and forwarding bus.
    // The forward index is cleared when the result retires and reloaded
    // whenever a new result lands in the register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_st   <= 1'b0;
            r_pend_wb_e <= 1'b0;
            r_pend_idx  <= '0;
            r_pend_len  <= '0;
            r_pend_lo   <= '0;
            r_pend_uns  <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            r_wb_e      <= 1'b0;
            r_wb_idx    <= '0;
            r_wb_data   <= '0;
            r_fwd_idx   <= '0;
            r_ma_ack    <= 1'b0;
            r_misalign  <= 1'b0;
        end else begin
            r_ma_ack <= 1'b0;
            if (r_state == MA_OUT && wb_ready) r_fwd_idx <= '0;

            if (w_accept) begin
                r_pend_st   <= (in_rw_e == RW_ST);
                r_pend_wb_e <= in_wb_e;
                r_pend_idx  <= in_wb_idx;
                r_pend_len  <= in_rw_len;
                r_pend_lo   <= in_ans[1:0];
                r_pend_uns  <= in_ld_uns;
                if (!w_is_mem) begin
                    r_wb_data <= in_ans;
                    r_wb_e    <= in_wb_e;
                    r_wb_idx  <= in_wb_idx;
                    if (in_wb_e && in_wb_idx != 5'd0) begin
                        r_fwd_idx <= in_wb_idx;
                        r_ma_ack  <= 1'b1;
                    end else begin
                        r_fwd_idx <= '0;
                    end
                end else if (w_misalign) begin
                    r_misalign <= 1'b1;
                    r_wb_data  <= '0;
                    r_wb_e     <= 1'b0;
                    r_wb_idx   <= in_wb_idx;
                    r_fwd_idx  <= '0;
                end else begin
                    r_mem_req   <= 1'b1;
                    r_mem_we    <= (in_rw_e == RW_ST);
                    r_mem_addr  <= {w_addr[ADDR_W-1:2], 2'b00};
                    r_mem_wdata <= w_fmt_wdata;
                    r_mem_be    <= w_fmt_be;
                    r_fwd_idx   <= '0;
                end
            end else if (r_state == MA_MEM && mem_ack) begin
                r_mem_req <= 1'b0;
                r_mem_we  <= 1'b0;
                r_wb_idx  <= r_pend_idx;
                if (r_pend_st) begin
                    r_wb_data <= '0;
                    r_wb_e    <= 1'b0;
                end else begin
                    r_wb_data <= w_fmt_ld;
                    r_wb_e    <= r_pend_wb_e;
                    if (r_pend_wb_e && r_pend_idx != 5'd0) begin
                        r_fwd_idx <= r_pend_idx;
                        r_ma_ack  <= 1'b1;
                    end
                end
            end
        end
    end

    assign mem_req      = r_mem_req;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign mem_be       = r_mem_be;
    assign wb_valid     = (r_state == MA_OUT);
    assign wb_e_out     = r_wb_e;
    assign wb_idx_out   = r_wb_idx;
    assign wb_data      = r_wb_data;
    assign MA_fwd_idx   = r_fwd_idx;
    assign MA_fwd_val   = 32'(r_wb_data);
    assign MA_ack       = r_ma_ack;
    assign misalign_err = r_misalign;

endmodule
